lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store control stage directly upstream of the data memory block. Accepts one memory micro-op at a time from EX over a valid/ready handshake and sequences the memory's timing: read captured at posedge, write committed at negedge, and read data muxed combinationally from the held address and width. Checks alignment, sign-extends load data and hands the result to WB over a second valid/ready handshake.

Parameters:
XLEN, 64, address/data width (matches `RegWidth/`ImmWidth)
REGIDX_W, 5, destination register index width

Ports:
clk  in  1  single clock; all state on posedge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  EX presents a micro-op
in_ready  out  1  LSU can accept (high only in IDLE)
in_op  in  2  lsu_pkg::lsu_op_t: NONE, LOAD, STORE
in_wdt  in  `WdtTypeCnt  width code `Wdt8/16/32/64
in_sext  in  1  load result is sign-extended (0: zero-extended)
in_addr  in  XLEN  effective address
in_wdata  in  XLEN  store data, LSB-aligned
in_rd  in  REGIDX_W  destination register
mem_raddr  out  XLEN  read address to memory
mem_waddr  out  XLEN  write address to memory
mem_wdata  out  XLEN  write data to memory
mem_ren  out  1  read strobe
mem_wen  out  1  write strobe
mem_wdt  out  `WdtTypeCnt  width code to memory
mem_rdata  in  XLEN  zero-extended read data from memory
out_valid  out  1  result available to WB
out_ready  in  1  WB accepts
out_rdata  out  XLEN  extended load data (0 for STORE/NONE)
out_rd  out  REGIDX_W  destination register
out_exc  out  1  misaligned access (see Optional Feature)
out_badaddr  out  XLEN  faulting address when out_exc=1, else 0

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; every registered output and internal register cleared to 0. mem_ren/mem_wen are additionally gated with rst_n, so no access is issued during a reset cycle, even mid-STORE or mid-LOAD_REQ. An in-flight op is dropped; no out_valid follows.
- FSM states: IDLE, LOAD_REQ, LOAD_RSP, STORE, DONE.
- IDLE: in_ready=1. On in_valid, register op/wdt/sext/addr/wdata/rd. Next state: LOAD→LOAD_REQ, STORE→STORE, NONE→DONE.
- LOAD_REQ: mem_ren=1; mem_raddr=addr_q; mem_wdt=wdt_q. Next state LOAD_RSP.
- LOAD_RSP: mem_ren=0; mem_raddr and mem_wdt held at the same values, because memory output is combinational on them. At the end of the cycle, capture extended mem_rdata into out_rdata. Next state DONE.
- STORE: mem_wen=1 for exactly one cycle, so the write commits on that cycle's negedge; mem_waddr=addr_q, mem_wdata=wdata_q, mem_wdt=wdt_q. Next state DONE.
- DONE: out_valid=1 with stable out_*. If out_ready in the same cycle, go to IDLE and clear out_valid. No new op is accepted in DONE (no bypass to IDLE acceptance).
- Latency, measured from the accept edge (cycle 0): NONE out_valid at cycle 1; STORE at cycle 2; LOAD at cycle 3. Minimum throughput is one op per 2/3/4 cycles.
- Outside their states, mem_ren=0 and mem_wen=0. Address, data and width outputs hold their last value.
- Extension rules on the low 8/16/32 bits of mem_rdata: sext=1 replicates the top bit; sext=0 zero-fills. Wdt64 passes through unchanged.
- Misalignment conditions: Wdt16 addr[0]≠0; Wdt32 addr[1:0]≠0; Wdt64 addr[2:0]≠0. Wdt8 is never misaligned.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a misaligned LOAD/STORE goes IDLE→DONE directly, with no mem_ren/mem_wen, out_exc=1, out_badaddr=addr, out_rdata=0.
- Undefined: out_exc and out_badaddr are tied to 0, and misaligned accesses are issued to memory unchanged.

Decomposition:
- lsu_pkg: lsu_op_t enum, lsu_state_t enum, the misalignment-check function. Width codes are reused from defines.v `Wdt*; they are not redefined.
- One sub-module, lsu_load_ext: combinational extension of mem_rdata by wdt/sext.

Test Plan:
- LOAD Wdt32 sext=1 addr 0x80000004, memory word 0xFFFF8001 → mem_ren high exactly in cycle 1; out_valid in cycle 3 with out_rdata 0xFFFFFFFF_FFFF8001.
- LOAD Wdt8 sext=0 addr 0x80000003, byte 0x9C → out_rdata 0x9C; with sext=1 → 0xFFFFFFFF_FFFFFF9C.
- STORE Wdt16 addr 0x80000010 wdata 0x1234 → mem_wen high one cycle with mem_wdt=`Wdt16; a following LOAD Wdt16 returns 0x1234.
- out_ready held low 5 cycles in DONE → out_valid and out_* stable, in_ready=0; out_ready=1 → IDLE on the next cycle.
- LOAD Wdt64 addr 0x80000004 → with LSU_MISALIGN_TRAP_EN: no mem_ren, out_exc=1, out_badaddr=0x80000004 at cycle 1; without it: normal 3-cycle load, out_exc=0.
- rst_n low during the STORE state → mem_wen=0 that cycle, memory unchanged, state IDLE, out_valid=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and the alignment check for the load/store control stage.
// Width codes come from the project-wide `Wdt* defines; fallbacks apply only when those are absent.
`ifndef WdtTypeCnt
`define WdtTypeCnt 2
`endif
`ifndef Wdt8
`define Wdt8 2'd0
`endif
`ifndef Wdt16
`define Wdt16 2'd1
`endif
`ifndef Wdt32
`define Wdt32 2'd2
`endif
`ifndef Wdt64
`define Wdt64 2'd3
`endif

package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_NONE  = 2'd0,
    LSU_LOAD  = 2'd1,
    LSU_STORE = 2'd2
  } lsu_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_LOAD_RSP,
    S_STORE,
    S_DONE
  } lsu_state_t;

  function automatic logic misaligned(input logic [`WdtTypeCnt-1:0] wdt,
                                      input logic [2:0] addr_lo);
    case (wdt)
      `Wdt16:  misaligned = addr_lo[0];
      `Wdt32:  misaligned = |addr_lo[1:0];
      `Wdt64:  misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_ext.sv
// Combinational sign/zero extension of memory read data by access width.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [`WdtTypeCnt-1:0] wdt,
  input  logic                   sext,
  input  logic [XLEN-1:0]        rdata,
  output logic [XLEN-1:0]        ext
);

  always_comb begin
    ext = rdata;
    case (wdt)
      `Wdt8:   ext = {{(XLEN-8){sext & rdata[7]}}, rdata[7:0]};
      `Wdt16:  ext = {{(XLEN-16){sext & rdata[15]}}, rdata[15:0]};
      `Wdt32:  ext = {{(XLEN-32){sext & rdata[31]}}, rdata[31:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer in front of the data memory (read at posedge, write at negedge).
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int REGIDX_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  lsu_op_t                in_op,
  input  logic [`WdtTypeCnt-1:0] in_wdt,
  input  logic                   in_sext,
  input  logic [XLEN-1:0]        in_addr,
  input  logic [XLEN-1:0]        in_wdata,
  input  logic [REGIDX_W-1:0]    in_rd,
  output logic [XLEN-1:0]        mem_raddr,
  output logic [XLEN-1:0]        mem_waddr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [`WdtTypeCnt-1:0] mem_wdt,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_rdata,
  output logic [REGIDX_W-1:0]    out_rd,
  output logic                   out_exc,
  output logic [XLEN-1:0]        out_badaddr
);

  lsu_state_t      state;
  logic            sext_q;
  logic            ren_q;
  logic            wen_q;
  logic            trap;
  logic [XLEN-1:0] ext_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic            exc_q;
  logic [XLEN-1:0] badaddr_q;

  assign trap        = misaligned(in_wdt, in_addr[2:0]) &&
                       (in_op == LSU_LOAD || in_op == LSU_STORE);
  assign out_exc     = exc_q;
  assign out_badaddr = badaddr_q;
`else
  assign trap        = 1'b0;
  assign out_exc     = 1'b0;
  assign out_badaddr = '0;
`endif

  lsu_load_ext #(.XLEN(XLEN)) u_ext (
    .wdt   (mem_wdt),
    .sext  (sext_q),
    .rdata (mem_rdata),
    .ext   (ext_data)
  );

  assign in_ready = (state == S_IDLE);
  // Strobes are gated so a reset cycle can never issue a memory access.
  assign mem_ren  = ren_q & rst_n;
  assign mem_wen  = wen_q & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sext_q    <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wdt   <= '0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_rd    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_q     <= 1'b0;
      badaddr_q <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sext_q    <= in_sext;
            out_rd    <= in_rd;
            out_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            exc_q     <= trap;
            badaddr_q <= trap ? in_addr : '0;
`endif
            if (trap) begin
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              case (in_op)
                LSU_LOAD: begin
                  ren_q     <= 1'b1;
                  mem_raddr <= in_addr;
                  mem_wdt   <= in_wdt;
                  state     <= S_LOAD_REQ;
                end
                LSU_STORE: begin
                  wen_q     <= 1'b1;
                  mem_waddr <= in_addr;
                  mem_wdata <= in_wdata;
                  mem_wdt   <= in_wdt;
                  state     <= S_STORE;
                end
                default: begin
                  out_valid <= 1'b1;
                  state     <= S_DONE;
                end
              endcase
            end
          end
        end
        S_LOAD_REQ: begin
          ren_q <= 1'b0;
          state <= S_LOAD_RSP;
        end
        // Address and width still held, so mem_rdata is valid for capture here.
        S_LOAD_RSP: begin
          out_rdata <= ext_data;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_STORE: begin
          wen_q     <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-addressed memory model (combinational read, negedge write).
`ifndef WdtTypeCnt
`define WdtTypeCnt 2
`endif
`ifndef Wdt8
`define Wdt8 2'd0
`endif
`ifndef Wdt16
`define Wdt16 2'd1
`endif
`ifndef Wdt32
`define Wdt32 2'd2
`endif
`ifndef Wdt64
`define Wdt64 2'd3
`endif

module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  lsu_op_t                in_op = LSU_NONE;
  logic [`WdtTypeCnt-1:0] in_wdt = '0;
  logic                   in_sext = 1'b0;
  logic [63:0]            in_addr = '0;
  logic [63:0]            in_wdata = '0;
  logic [4:0]             in_rd = '0;
  logic [63:0]            mem_raddr, mem_waddr, mem_wdata;
  logic                   mem_ren, mem_wen;
  logic [`WdtTypeCnt-1:0] mem_wdt;
  logic [63:0]            mem_rdata;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [63:0]            out_rdata;
  logic [4:0]             out_rd;
  logic                   out_exc;
  logic [63:0]            out_badaddr;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.XLEN(64), .REGIDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_wdt(in_wdt),
    .in_sext(in_sext), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdt(mem_wdt), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_rd(out_rd), .out_exc(out_exc), .out_badaddr(out_badaddr)
  );

  always #5 clk = ~clk;

  // Memory model: 256 bytes, little-endian, indexed by address[7:0]
  logic [7:0]  mem [0:255];
  logic [63:0] rd_all;
  bit          loaded = 1'b0;

  always_comb begin
    rd_all = '0;
    for (int i = 0; i < 8; i++) rd_all[i*8 +: 8] = mem[mem_raddr[7:0] + 8'(i)];
    mem_rdata = rd_all;
    case (mem_wdt)
      `Wdt8:   mem_rdata = {56'd0, rd_all[7:0]};
      `Wdt16:  mem_rdata = {48'd0, rd_all[15:0]};
      `Wdt32:  mem_rdata = {32'd0, rd_all[31:0]};
      default: mem_rdata = rd_all;
    endcase
  end

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h03] = 8'h9C;
      mem[8'h04] = 8'h01; mem[8'h05] = 8'h80; mem[8'h06] = 8'hFF; mem[8'h07] = 8'hFF;
      mem[8'h08] = 8'h11; mem[8'h09] = 8'h22; mem[8'h0A] = 8'h33; mem[8'h0B] = 8'h44;
      mem[8'h12] = 8'h55;
      loaded = 1'b1;
    end else if (mem_wen) begin
      for (int i = 0; i < 8; i++)
        if (i < (32'sd1 <<< mem_wdt)) mem[mem_waddr[7:0] + 8'(i)] = mem_wdata[i*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op; returns one step after the accept edge (cycle 1).
  task automatic issue(input lsu_op_t op, input logic [1:0] wdt, input logic sext,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_wdt = wdt; in_sext = sext;
    in_addr = addr; in_wdata = wd; in_rd = rd;
    step();
    in_valid = 1'b0; in_op = LSU_NONE;
  endtask

  task automatic wait_done(output int lat, output int nren, output int ren_at,
                           output int nwen, output logic [1:0] wdt_wen);
    lat = -1; nren = 0; ren_at = -1; nwen = 0; wdt_wen = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      if (mem_ren) begin
        nren++;
        if (ren_at < 0) ren_at = c;
      end
      if (mem_wen) begin
        nwen++;
        wdt_wen = mem_wdt;
      end
      if (out_valid) begin
        lat = c;
        break;
      end
      step();
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  int          lat, nren, ren_at, nwen;
  logic [1:0]  wdt_wen;
  logic [63:0] held;

  initial begin
    // Reset
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    rst_n = 1'b1;
    step();

    // LOAD Wdt32 sext
    issue(LSU_LOAD, `Wdt32, 1'b1, 64'h8000_0004, 64'd0, 5'd5);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("ld32s_lat", 64'(lat), 64'd3);
    chk("ld32s_ren_cnt", 64'(nren), 64'd1);
    chk("ld32s_ren_at", 64'(ren_at), 64'd1);
    chk("ld32s_raddr", mem_raddr, 64'h8000_0004);
    chk("ld32s_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_8001);
    chk("ld32s_rd", 64'(out_rd), 64'd5);
    chk("ld32s_exc", 64'(out_exc), 64'd0);
    release_out("ld32s");

    // LOAD Wdt32 zero-extended
    issue(LSU_LOAD, `Wdt32, 1'b0, 64'h8000_0004, 64'd0, 5'd6);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("ld32u_rdata", out_rdata, 64'h0000_0000_FFFF_8001);
    release_out("ld32u");

    // LOAD Wdt8 zero- and sign-extended
    issue(LSU_LOAD, `Wdt8, 1'b0, 64'h8000_0003, 64'd0, 5'd7);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("ld8u_lat", 64'(lat), 64'd3);
    chk("ld8u_rdata", out_rdata, 64'h0000_0000_0000_009C);
    release_out("ld8u");
    issue(LSU_LOAD, `Wdt8, 1'b1, 64'h8000_0003, 64'd0, 5'd8);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("ld8s_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FF9C);
    chk("ld8s_rd", 64'(out_rd), 64'd8);
    release_out("ld8s");

    // STORE Wdt16; upper wdata bits must not reach memory
    issue(LSU_STORE, `Wdt16, 1'b0, 64'h8000_0010, 64'hDEAD_0000_0000_1234, 5'd9);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("st16_lat", 64'(lat), 64'd2);
    chk("st16_wen_cnt", 64'(nwen), 64'd1);
    chk("st16_wdt", 64'(wdt_wen), 64'(`Wdt16));
    chk("st16_ren_cnt", 64'(nren), 64'd0);
    chk("st16_waddr", mem_waddr, 64'h8000_0010);
    chk("st16_wdata", mem_wdata, 64'hDEAD_0000_0000_1234);
    chk("st16_rdata", out_rdata, 64'd0);
    chk("st16_mem10", 64'(mem[8'h10]), 64'h34);
    chk("st16_mem11", 64'(mem[8'h11]), 64'h12);
    chk("st16_mem12", 64'(mem[8'h12]), 64'h55);
    release_out("st16");

    // LOAD Wdt16 back, then hold WB back-pressure for 5 cycles
    issue(LSU_LOAD, `Wdt16, 1'b0, 64'h8000_0010, 64'd0, 5'd10);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("ld16_lat", 64'(lat), 64'd3);
    chk("ld16_rdata", out_rdata, 64'h0000_0000_0000_1234);
    held = out_rdata;
    in_valid = 1'b1; in_op = LSU_NONE;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_rdata", out_rdata, held);
      chk("bp_rd", 64'(out_rd), 64'd10);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid = 1'b0;
    release_out("bp");

    // NONE op
    issue(LSU_NONE, `Wdt8, 1'b0, 64'h8000_0000, 64'd0, 5'd11);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
    chk("none_lat", 64'(lat), 64'd1);
    chk("none_rdata", out_rdata, 64'd0);
    chk("none_rd", 64'(out_rd), 64'd11);
    release_out("none");

    // Misaligned LOAD Wdt64
    issue(LSU_LOAD, `Wdt64, 1'b0, 64'h8000_0004, 64'd0, 5'd12);
    wait_done(lat, nren, ren_at, nwen, wdt_wen);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis64_lat", 64'(lat), 64'd1);
    chk("mis64_ren_cnt", 64'(nren), 64'd0);
    chk("mis64_exc", 64'(out_exc), 64'd1);
    chk("mis64_badaddr", out_badaddr, 64'h8000_0004);
    chk("mis64_rdata", out_rdata, 64'd0);
`else
    chk("mis64_lat", 64'(lat), 64'd3);
    chk("mis64_ren_cnt", 64'(nren), 64'd1);
    chk("mis64_exc", 64'(out_exc), 64'd0);
    chk("mis64_badaddr", out_badaddr, 64'd0);
    chk("mis64_rdata", out_rdata, 64'h4433_2211_FFFF_8001);
`endif
    release_out("mis64");

    // Reset asserted while in the STORE state
    issue(LSU_STORE, `Wdt8, 1'b0, 64'h8000_0020, 64'h77, 5'd3);
    chk("rs_wen_before", 64'(mem_wen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_wen_gated", 64'(mem_wen), 64'd0);
    step();
    rst_n = 1'b1;
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    chk("rs_mem20", 64'(mem[8'h20]), 64'h00);
    step(); step();
    chk("rs_no_valid", 64'(out_valid), 64'd0);
    chk("rs_no_wen", 64'(mem_wen), 64'd0);
    chk("rs_mem20_late", 64'(mem[8'h20]), 64'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
